// File: rtl/way_sequencer_pkg.sv
// Shared encodings for the waypoint sequencer and the SPI message interpreter.
// State values double as BEHAVIOR status codes so both sides agree on them.
package way_pkg;

    localparam int WAY_Q_WIDTH = 15;
    localparam int PATH_W      = 3;
    localparam int IDX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_TRACK   = 3'd2,
        ST_DWELL   = 3'd3,
        ST_DONE    = 3'd4,
        ST_STOPPED = 3'd5
    } wayState_t;

    localparam logic [7:0] BEH_IDLE    = 8'h00;
    localparam logic [7:0] BEH_LOAD    = 8'h01;
    localparam logic [7:0] BEH_TRACK   = 8'h02;
    localparam logic [7:0] BEH_DWELL   = 8'h03;
    localparam logic [7:0] BEH_DONE    = 8'h04;
    localparam logic [7:0] BEH_STOPPED = 8'h05;

    function automatic logic [7:0] behaviorCode(input wayState_t s);
        case (s)
            ST_LOAD:    behaviorCode = BEH_LOAD;
            ST_TRACK:   behaviorCode = BEH_TRACK;
            ST_DWELL:   behaviorCode = BEH_DWELL;
            ST_DONE:    behaviorCode = BEH_DONE;
            ST_STOPPED: behaviorCode = BEH_STOPPED;
            default:    behaviorCode = BEH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/way_sequencer_rom.sv
// Waypoint table: {path, index} -> {x, y, last}, one-cycle registered read.
// Coordinates are signed fixed point built from the format's unit value.
module way_rom
    import way_pkg::*;
#(
    parameter int N_WIDTH = 32,
    parameter int Q_WIDTH = WAY_Q_WIDTH
)(
    input  logic               clk,
    input  logic [PATH_W-1:0]  path,
    input  logic [IDX_W-1:0]   index,
    output logic [N_WIDTH-1:0] romX,
    output logic [N_WIDTH-1:0] romY,
    output logic               romLast
);

    localparam logic signed [N_WIDTH-1:0] ONE     = N_WIDTH'(1) << Q_WIDTH;
    localparam logic signed [N_WIDTH-1:0] HALF    = ONE >>> 1;
    localparam logic signed [N_WIDTH-1:0] QUARTER = ONE >>> 2;
    localparam logic signed [N_WIDTH-1:0] EIGHTH  = ONE >>> 3;

    logic signed [N_WIDTH-1:0] tblX;
    logic signed [N_WIDTH-1:0] tblY;
    logic signed [N_WIDTH-1:0] step;
    logic signed [N_WIDTH-1:0] pathScale;
    logic                      tblLast;

    always_comb begin
        tblX      = '0;
        tblY      = '0;
        tblLast   = 1'b0;
        step      = N_WIDTH'(index) + N_WIDTH'(1);
        pathScale = N_WIDTH'(path);
        case (path)
            3'd1: begin
                case (index)
                    3'd0: begin tblX = ONE;       tblY = HALF;       end
                    3'd1: begin tblX = ONE + ONE; tblY = -ONE;       end
                    3'd2: begin tblX = -HALF;     tblY = ONE + HALF; tblLast = 1'b1; end
                    default: ;
                endcase
            end
            3'd2: begin
                case (index)
                    3'd0: begin tblX = QUARTER; tblY = QUARTER;      end
                    3'd1: begin tblX = -ONE;    tblY = -(ONE + ONE); tblLast = 1'b1; end
                    default: ;
                endcase
            end
            // Path 3 fills every slot without a last flag: ends on the index limit
            3'd3: begin
                tblX = step * EIGHTH;
                tblY = -(step * QUARTER);
            end
            default: begin
                if (path != 3'd0 && index == 3'd0) begin
                    tblX    = pathScale * QUARTER;
                    tblY    = -(pathScale * QUARTER);
                    tblLast = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        romX    <= tblX;
        romY    <= tblY;
        romLast <= tblLast;
    end

endmodule

// File: rtl/way_sequencer.sv
// Path sequencer: runs a selected waypoint path, presents targets to the motion
// controller, detects arrival, dwells at each waypoint and reports status.
module way_sequencer
    import way_pkg::*;
#(
    parameter int          N_WIDTH      = 32,
    parameter int          Q_WIDTH      = WAY_Q_WIDTH,
    parameter int          INT_WIDTH    = 8,
    parameter int          MAX_WP       = 8,
    parameter logic [31:0] TOL          = 32'd1638,
    parameter int          DWELL_CYCLES = 25_000_000
)(
    input  logic                 WAY_SEQUENCER_CLOCK_50,
    input  logic                 WAY_SEQUENCER_RESET_InLow,
    input  logic [PATH_W-1:0]    WAY_SEQUENCER_WAYSELECT_InBus,
    input  logic                 WAY_SEQUENCER_BEGINSIGNAL_InLow,
    input  logic                 WAY_SEQUENCER_STOPSIGNAL_InLow,
    input  logic [N_WIDTH-1:0]   WAY_SEQUENCER_POSX_InBus,
    input  logic [N_WIDTH-1:0]   WAY_SEQUENCER_POSY_InBus,
    output logic [N_WIDTH-1:0]   WAY_SEQUENCER_TARGETX_OutBus,
    output logic [N_WIDTH-1:0]   WAY_SEQUENCER_TARGETY_OutBus,
    output logic                 WAY_SEQUENCER_ENABLE_Out,
    output logic [IDX_W-1:0]     WAY_SEQUENCER_WPINDEX_OutBus,
    output logic [INT_WIDTH-1:0] WAY_SEQUENCER_BEHAVIOR_OutBus,
    output logic                 WAY_SEQUENCER_DONE_Out
);

    localparam int                      CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]        DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic signed [N_WIDTH:0] TOL_EXT    = (N_WIDTH+1)'(TOL);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(MAX_WP - 1);

    wayState_t                 state;
    wayState_t                 stateNext;
    logic                      prevBegin;
    logic                      prevStop;
    logic                      beginEvt;
    logic                      stopEvt;
    logic                      startReq;
    logic                      dwellEnd;
    logic                      finalWp;
    logic                      arriveNow;
    logic                      arrive;
    logic                      lastFlag;
    logic [PATH_W-1:0]         path;
    logic [PATH_W-1:0]         romPath;
    logic [IDX_W-1:0]          index;
    logic [IDX_W-1:0]          romIndex;
    logic signed [N_WIDTH-1:0] targetX;
    logic signed [N_WIDTH-1:0] targetY;
    logic [N_WIDTH-1:0]        romX;
    logic [N_WIDTH-1:0]        romY;
    logic                      romLast;
    logic [CNT_W-1:0]          dwellCnt;

    // One extra bit keeps the pose-target difference and its magnitude exact
    function automatic logic signed [N_WIDTH:0] absDiff(input logic [N_WIDTH-1:0] pos,
                                                        input logic signed [N_WIDTH-1:0] tgt);
        logic signed [N_WIDTH:0] d;
        d = $signed({pos[N_WIDTH-1], pos}) - $signed({tgt[N_WIDTH-1], tgt});
        return (d < 0) ? -d : d;
    endfunction

    always_comb begin
        beginEvt  = prevBegin & ~WAY_SEQUENCER_BEGINSIGNAL_InLow;
        stopEvt   = prevStop & ~WAY_SEQUENCER_STOPSIGNAL_InLow;
        dwellEnd  = (state == ST_DWELL) && (dwellCnt == DWELL_LAST);
        finalWp   = lastFlag || (index == LAST_IDX);
        arriveNow = (absDiff(WAY_SEQUENCER_POSX_InBus, targetX) <= TOL_EXT) &&
                    (absDiff(WAY_SEQUENCER_POSY_InBus, targetY) <= TOL_EXT);

        startReq = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: startReq = beginEvt && (WAY_SEQUENCER_WAYSELECT_InBus != '0);
            ST_STOPPED:       startReq = beginEvt && WAY_SEQUENCER_STOPSIGNAL_InLow &&
                                         (WAY_SEQUENCER_WAYSELECT_InBus != '0);
            default:          startReq = 1'b0;
        endcase

        stateNext = state;
        if (stopEvt) begin
            stateNext = ST_STOPPED;
        end else if (startReq) begin
            stateNext = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  stateNext = ST_TRACK;
                ST_TRACK: if (arrive) stateNext = ST_DWELL;
                ST_DWELL: if (dwellEnd) stateNext = finalWp ? ST_DONE : ST_LOAD;
                default:  stateNext = state;
            endcase
        end

        // ROM is addressed with the values about to be latched, so its data is ready in LOAD
        romPath  = path;
        romIndex = index;
        if (startReq) begin
            romPath  = WAY_SEQUENCER_WAYSELECT_InBus;
            romIndex = '0;
        end else if (state == ST_DWELL) begin
            romIndex = index + 1'b1;
        end
    end

    way_rom #(
        .N_WIDTH (N_WIDTH),
        .Q_WIDTH (Q_WIDTH)
    ) uRom (
        .clk     (WAY_SEQUENCER_CLOCK_50),
        .path    (romPath),
        .index   (romIndex),
        .romX    (romX),
        .romY    (romY),
        .romLast (romLast)
    );

    always_ff @(posedge WAY_SEQUENCER_CLOCK_50 or negedge WAY_SEQUENCER_RESET_InLow) begin
        if (!WAY_SEQUENCER_RESET_InLow) begin
            state                         <= ST_IDLE;
            prevBegin                     <= 1'b1;
            prevStop                      <= 1'b1;
            path                          <= '0;
            index                         <= '0;
            targetX                       <= '0;
            targetY                       <= '0;
            lastFlag                      <= 1'b0;
            arrive                        <= 1'b0;
            dwellCnt                      <= '0;
            WAY_SEQUENCER_ENABLE_Out      <= 1'b0;
            WAY_SEQUENCER_BEHAVIOR_OutBus <= '0;
            WAY_SEQUENCER_DONE_Out        <= 1'b0;
        end else begin
            prevBegin                     <= WAY_SEQUENCER_BEGINSIGNAL_InLow;
            prevStop                      <= WAY_SEQUENCER_STOPSIGNAL_InLow;
            state                         <= stateNext;
            WAY_SEQUENCER_ENABLE_Out      <= (stateNext == ST_TRACK);
            WAY_SEQUENCER_BEHAVIOR_OutBus <= INT_WIDTH'(behaviorCode(stateNext));
            WAY_SEQUENCER_DONE_Out        <= dwellEnd && (stateNext == ST_DONE);
            // Arrival only counts against the target being tracked, never a stale one
            arrive                        <= (state == ST_TRACK) && arriveNow;
            dwellCnt                      <= (state == ST_DWELL && stateNext == ST_DWELL) ?
                                             dwellCnt + 1'b1 : '0;
            if (stateNext == ST_LOAD) begin
                path  <= romPath;
                index <= romIndex;
            end
            if (state == ST_LOAD && stateNext == ST_TRACK) begin
                targetX  <= $signed(romX);
                targetY  <= $signed(romY);
                lastFlag <= romLast;
            end
        end
    end

    assign WAY_SEQUENCER_TARGETX_OutBus = targetX;
    assign WAY_SEQUENCER_TARGETY_OutBus = targetY;
    assign WAY_SEQUENCER_WPINDEX_OutBus = index;

endmodule

// File: tb/tb_way_sequencer.sv
// Directed-plus-random bench for way_sequencer with a short dwell time.
module tb_way_sequencer;

    localparam int DWELL = 4;
    localparam int TOL   = 1638;
    localparam int FAR   = 4_000_000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        beginN;
    logic        stopN;
    logic [2:0]  waySel;
    logic [31:0] posX;
    logic [31:0] posY;
    logic [31:0] tgtX;
    logic [31:0] tgtY;
    logic        en;
    logic [2:0]  wpIdx;
    logic [7:0]  beh;
    logic        done;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    way_sequencer #(.DWELL_CYCLES(DWELL)) dut (
        .WAY_SEQUENCER_CLOCK_50          (clk),
        .WAY_SEQUENCER_RESET_InLow       (rstN),
        .WAY_SEQUENCER_WAYSELECT_InBus   (waySel),
        .WAY_SEQUENCER_BEGINSIGNAL_InLow (beginN),
        .WAY_SEQUENCER_STOPSIGNAL_InLow  (stopN),
        .WAY_SEQUENCER_POSX_InBus        (posX),
        .WAY_SEQUENCER_POSY_InBus        (posY),
        .WAY_SEQUENCER_TARGETX_OutBus    (tgtX),
        .WAY_SEQUENCER_TARGETY_OutBus    (tgtY),
        .WAY_SEQUENCER_ENABLE_Out        (en),
        .WAY_SEQUENCER_WPINDEX_OutBus    (wpIdx),
        .WAY_SEQUENCER_BEHAVIOR_OutBus   (beh),
        .WAY_SEQUENCER_DONE_Out          (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waypoint table in real units scaled by 2^15 (1.0 = 32768)
    function automatic void refWp(input int p, input int i, output int x, output int y, output bit last);
        x = 0; y = 0; last = 1'b0;
        case (p)
            1: case (i)
                   0: begin x = 32768;  y = 16384;  end
                   1: begin x = 65536;  y = -32768; end
                   2: begin x = -16384; y = 49152;  last = 1'b1; end
                   default: ;
               endcase
            2: case (i)
                   0: begin x = 8192;   y = 8192;   end
                   1: begin x = -32768; y = -65536; last = 1'b1; end
                   default: ;
               endcase
            3: begin x = (i + 1) * 4096; y = -(i + 1) * 8192; end
            default: if (i == 0) begin x = p * 8192; y = -p * 8192; last = 1'b1; end
        endcase
    endfunction

    task automatic startPath(input int p);
        waySel = 3'(p);
        beginN = 1'b0;
        tick();
        check("loadBeh", beh, 8'h01);
        check("loadEn", en, 0);
        check("loadIdx", wpIdx, 0);
        beginN = 1'b1;
        tick();
    endtask

    // Walks a running path from its first TRACK cycle to DONE, with WAYSELECT scrambled
    task automatic followPath(input int p);
        int tx, ty, px, py, sgn, i;
        bit tl, fin;
        i = 0;
        fin = 1'b0;
        while (!fin) begin
            refWp(p, i, tx, ty, tl);
            fin = tl || (i == 7);
            check("trackBeh", beh, 8'h02);
            check("trackEn", en, 1);
            check("tgtX", tgtX, unsigned'(tx));
            check("tgtY", tgtY, unsigned'(ty));
            check("wpIdx", wpIdx, unsigned'(i));

            sgn = ($urandom_range(0, 1) == 0) ? -1 : 1;
            px = tx;
            py = ty;
            if (i % 2 == 0) px = tx + sgn * (TOL + 1);
            else            py = ty + sgn * (TOL + 1);
            posX = px;
            posY = py;
            waySel = 3'($urandom_range(0, 7));
            repeat ($urandom_range(2, 3)) begin
                tick();
                check("offTolTrack", beh, 8'h02);
            end

            if (i == 0) begin
                px = tx - TOL;
                py = ty + TOL;
            end else begin
                px = tx + int'($urandom_range(0, 2 * TOL)) - TOL;
                py = ty + int'($urandom_range(0, 2 * TOL)) - TOL;
            end
            posX = px;
            posY = py;
            tick();
            check("arriveLatency", beh, 8'h02);
            tick();
            check("dwellBeh", beh, 8'h03);
            check("dwellEn", en, 0);
            posX = tx + FAR;
            posY = ty - FAR;
            for (int k = 1; k < DWELL; k++) begin
                tick();
                check("dwellHold", beh, 8'h03);
            end
            tick();
            if (fin) begin
                check("doneBeh", beh, 8'h04);
                check("donePulse", done, 1);
                check("doneEn", en, 0);
                tick();
                check("donePulseEnd", done, 0);
                check("doneBehHold", beh, 8'h04);
                check("doneTgtX", tgtX, unsigned'(tx));
                check("doneIdx", wpIdx, unsigned'(i));
            end else begin
                check("nextLoadBeh", beh, 8'h01);
                check("nextIdx", wpIdx, unsigned'(i + 1));
                check("noDone", done, 0);
                tick();
            end
            i++;
        end
    endtask

    initial begin
        int p, tx, ty;
        bit tl;

        rstN   = 1'b0;
        beginN = 1'b1;
        stopN  = 1'b1;
        waySel = 3'd0;
        posX   = FAR;
        posY   = FAR;
        repeat (3) tick();
        check("rstBeh", beh, 0);
        check("rstEn", en, 0);
        check("rstTgtX", tgtX, 0);
        check("rstTgtY", tgtY, 0);
        check("rstIdx", wpIdx, 0);
        check("rstDone", done, 0);
        rstN = 1'b1;
        tick();

        waySel = 3'd0;
        beginN = 1'b0;
        tick();
        check("sel0Idle", beh, 8'h00);
        beginN = 1'b1;
        tick();
        check("sel0Idle2", beh, 8'h00);

        startPath(1);
        followPath(1);

        waySel = 3'd0;
        beginN = 1'b0;
        tick();
        check("sel0Done", beh, 8'h04);
        refWp(1, 2, tx, ty, tl);
        check("sel0DoneTgt", tgtX, unsigned'(tx));
        beginN = 1'b1;
        tick();

        // Stop and begin falling together: stop wins
        startPath(2);
        check("preStopBeh", beh, 8'h02);
        beginN = 1'b0;
        stopN  = 1'b0;
        tick();
        check("stopBeh", beh, 8'h05);
        check("stopEn", en, 0);
        check("stopIdx", wpIdx, 0);
        refWp(2, 0, tx, ty, tl);
        check("stopTgtX", tgtX, unsigned'(tx));
        check("stopTgtY", tgtY, unsigned'(ty));
        beginN = 1'b1;
        tick();
        beginN = 1'b0;
        tick();
        check("stopHeldBegin", beh, 8'h05);
        beginN = 1'b1;
        stopN  = 1'b1;
        tick();
        check("stopReleased", beh, 8'h05);
        startPath(2);
        followPath(2);

        startPath(3);
        followPath(3);

        // Asynchronous reset during TRACK, then during DWELL
        startPath(1);
        #4 rstN = 1'b0;
        #1;
        check("rstTrackBeh", beh, 0);
        check("rstTrackEn", en, 0);
        check("rstTrackTgt", tgtX, 0);
        tick();
        rstN = 1'b1;
        tick();
        startPath(1);
        refWp(1, 0, tx, ty, tl);
        posX = tx;
        posY = ty;
        tick();
        tick();
        check("preRstDwell", beh, 8'h03);
        tick();
        #4 rstN = 1'b0;
        #1;
        check("rstDwellBeh", beh, 0);
        check("rstDwellIdx", wpIdx, 0);
        check("rstDwellTgtY", tgtY, 0);
        tick();
        rstN = 1'b1;
        posX = FAR;
        posY = FAR;
        tick();
        check("postRstIdle", beh, 0);
        startPath(1);
        followPath(1);

        repeat (3) begin
            p = int'($urandom_range(1, 7));
            startPath(p);
            followPath(p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
